// File: rtl/multicycle_serial_adder_pkg.sv
// Shared definitions for the multi-cycle serial adder/subtractor:
// FSM state encodings and default operand/chunk widths.
package multicycle_serial_adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/multicycle_serial_adder_chunk_adder.sv
// Combinational ripple of CHUNK full-adder cells. Exposes the carry into the
// top cell so the caller can form signed overflow on the final chunk.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_top
);

   logic [CHUNK:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign co    = c[CHUNK];
   assign c_top = c[CHUNK-1];

endmodule

// File: rtl/multicycle_serial_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// carrying between chunks in a register. start/busy/done handshake.
module multicycle_serial_adder
   import multicycle_serial_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

   state_e             state_q;
   logic [WIDTH-1:0]   a_q, b_q, acc_q;
   logic [WIDTH-1:0]   a_d, b_d, acc_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q;
   logic               busy_q, done_q, cout_q, ovf_q;
   logic [WIDTH-1:0]   sum_q;
   logic [CHUNK-1:0]   ch_s;
   logic               ch_co, ch_ctop;

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_q[CHUNK-1:0]),
      .b     (b_q[CHUNK-1:0]),
      .ci    (carry_q),
      .s     (ch_s),
      .co    (ch_co),
      .c_top (ch_ctop)
   );

   // Operands shift down one chunk per cycle; result bits enter at the top so
   // after NCHUNK cycles the accumulator holds the full result in place.
   always_comb begin
      a_d   = a_q >> CHUNK;
      b_d   = b_q >> CHUNK;
      acc_d = (acc_q >> CHUNK) | (WIDTH'(ch_s) << (WIDTH - CHUNK));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? 1'b1 : cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_d;
               b_q     <= b_d;
               acc_q   <= acc_d;
               carry_q <= ch_co;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  sum_q   <= acc_d;
                  cout_q  <= ch_co;
                  ovf_q   <= ch_co ^ ch_ctop;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_serial_adder.sv
// Scoreboard bench for multicycle_serial_adder at CHUNK=4, CHUNK=1 and CHUNK=16
// (WIDTH=16) using hand-computed directed vectors.
module tb_multicycle_serial_adder;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_r [3];
   logic        sub_r   [3];
   logic        cin_r   [3];
   logic [15:0] a_r     [3];
   logic [15:0] b_r     [3];
   logic        busy_w  [3];
   logic        done_w  [3];
   logic        cout_w  [3];
   logic        ovf_w   [3];
   logic [15:0] sum_w   [3];

   exp_t        expq [3][$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multicycle_serial_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
      .clk(clk), .rst_n(rst_n), .start(start_r[0]), .sub(sub_r[0]), .a(a_r[0]), .b(b_r[0]),
      .cin(cin_r[0]), .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]),
      .ovf(ovf_w[0]));
   multicycle_serial_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .start(start_r[1]), .sub(sub_r[1]), .a(a_r[1]), .b(b_r[1]),
      .cin(cin_r[1]), .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]),
      .ovf(ovf_w[1]));
   multicycle_serial_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
      .clk(clk), .rst_n(rst_n), .start(start_r[2]), .sub(sub_r[2]), .a(a_r[2]), .b(b_r[2]),
      .cin(cin_r[2]), .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]),
      .ovf(ovf_w[2]));

   function automatic int nch(input int k);
      case (k)
         0:       return 4;
         1:       return 16;
         default: return 1;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         if (done_w[k] === 1'b1) begin
            if (expq[k].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done dut%0d: got done with sum %h, expected no completion",
                        k, sum_w[k]);
            end else begin
               e = expq[k].pop_front();
               chk($sformatf("sum_dut%0d", k), 32'(sum_w[k]), 32'(e.sum));
               chk($sformatf("cout_dut%0d", k), 32'(cout_w[k]), 32'(e.cout));
               chk($sformatf("ovf_dut%0d", k), 32'(ovf_w[k]), 32'(e.ovf));
               chk($sformatf("latency_dut%0d", k), cyc, e.cyc);
            end
         end
      end
   end

   task automatic push_exp(input int k, input logic [15:0] es, input logic ec, input logic eo);
      exp_t e;
      e.sum  = es;
      e.cout = ec;
      e.ovf  = eo;
      e.cyc  = cyc + 1 + nch(k);
      expq[k].push_back(e);
   endtask

   // Called just after a falling edge; drops start one cycle later and then
   // scrambles the operand inputs to show they are not sampled during RUN.
   task automatic issue(input int k, input logic s, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic [15:0] es, input logic ec, input logic eo);
      start_r[k] = 1'b1;
      sub_r[k]   = s;
      a_r[k]     = av;
      b_r[k]     = bv;
      cin_r[k]   = ci;
      push_exp(k, es, ec, eo);
      @(negedge clk);
      start_r[k] = 1'b0;
      a_r[k]     = 16'h5A5A;
      b_r[k]     = 16'hC3C3;
      sub_r[k]   = ~s;
      cin_r[k]   = ~ci;
   endtask

   task automatic wait_idle(input int k);
      int n = 0;
      while ((busy_w[k] !== 1'b0 || expq[k].size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL timeout dut%0d: got busy=%b pending=%0d, expected idle", k, busy_w[k],
                  expq[k].size());
         expq[k].delete();
      end
   endtask

   task automatic run_vectors(input int k);
      issue(k, 1'b0, 16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0); wait_idle(k);
      issue(k, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0); wait_idle(k);
      issue(k, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1); wait_idle(k);
      issue(k, 1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0); wait_idle(k);
      issue(k, 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1); wait_idle(k);
   endtask

   task automatic chk_cleared(input int k, input string tag);
      chk($sformatf("%s_busy_dut%0d", tag, k), 32'(busy_w[k]), 32'd0);
      chk($sformatf("%s_done_dut%0d", tag, k), 32'(done_w[k]), 32'd0);
      chk($sformatf("%s_sum_dut%0d", tag, k), 32'(sum_w[k]), 32'd0);
      chk($sformatf("%s_cout_dut%0d", tag, k), 32'(cout_w[k]), 32'd0);
      chk($sformatf("%s_ovf_dut%0d", tag, k), 32'(ovf_w[k]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected completion within time limit");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start_r[k] = 1'b0; sub_r[k] = 1'b0; cin_r[k] = 1'b0;
         a_r[k] = '0; b_r[k] = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) chk_cleared(k, "reset");
      rst_n = 1'b1;
      @(negedge clk);

      run_vectors(0);

      // start pulsed during RUN must be ignored
      issue(0, 1'b0, 16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0);
      start_r[0] = 1'b1; a_r[0] = 16'hAAAA; b_r[0] = 16'hAAAA;
      @(negedge clk);
      start_r[0] = 1'b0;
      wait_idle(0);

      // start held through the done cycle: second op accepted, period NCHUNK+1
      start_r[0] = 1'b1; sub_r[0] = 1'b1; a_r[0] = 16'h0005; b_r[0] = 16'h0007; cin_r[0] = 1'b0;
      push_exp(0, 16'hFFFE, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      chk("b2b_done_cycle", 32'(done_w[0]), 32'd1);
      sub_r[0] = 1'b0; a_r[0] = 16'h7FFF; b_r[0] = 16'h0000; cin_r[0] = 1'b1;
      push_exp(0, 16'h8000, 1'b0, 1'b1);
      @(negedge clk);
      start_r[0] = 1'b0;
      wait_idle(0);

      // asynchronous reset in the middle of RUN
      start_r[0] = 1'b1; sub_r[0] = 1'b0; a_r[0] = 16'hFFFF; b_r[0] = 16'h0001; cin_r[0] = 1'b0;
      @(negedge clk);
      start_r[0] = 1'b0;
      @(negedge clk);
      chk("midrun_busy", 32'(busy_w[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_cleared(0, "midrun_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(0, 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      wait_idle(0);

      run_vectors(1);
      run_vectors(2);

      for (int k = 0; k < 3; k++)
         chk($sformatf("drained_dut%0d", k), 32'(expq[k].size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
